// File: rtl/wb_store_queue_pkg.sv
// Shared types and constants for the write-back store queue.
package wb_pkg;

   // Bus tag: WRITE / MEMORY / DATA flags followed by 7 reserved zero bits
   localparam int unsigned REQTAG_W = 10;
   localparam logic WRITE  = 1'b1;
   localparam logic MEMORY = 1'b1;
   localparam logic DATA   = 1'b1;
   localparam logic [REQTAG_W-1:0] STORE_TAG = {WRITE, MEMORY, DATA, 7'b0};

   // Entries are stored at the maximum supported width; narrower
   // address/data parameters are zero-extended on write and sliced on read.
   localparam int unsigned STQ_ADDR_MAX_W = 64;
   localparam int unsigned STQ_DATA_MAX_W = 64;

   typedef struct packed {
      logic [STQ_ADDR_MAX_W-1:0] addr;
      logic [STQ_DATA_MAX_W-1:0] data;
   } stq_entry_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      WAIT   = 2'd2,
      RETIRE = 2'd3
   } stq_state_e;

endpackage

// File: rtl/wb_store_queue_if.sv
// Write-back enqueue port and D-cache request port of the store queue.
// Optional store-to-load forwarding signals appear when WB_STQ_FWD_EN is defined.
interface wb_store_queue_if
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64
);
   import wb_pkg::*;

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic                enq_valid;
   logic                enq_kill;
   logic [ADDR_W-1:0]   enq_addr;
   logic [DATA_W-1:0]   enq_data;
   logic                enq_ready;
   logic                reqcyc;
   logic [ADDR_W-1:0]   req;
   logic [DATA_W-1:0]   reqdata;
   logic [REQTAG_W-1:0] reqtag;
   logic                reqack;
   logic                writeack;
   logic                store_done;
   logic [CNT_W-1:0]    count;
   logic                empty;
`ifdef WB_STQ_FWD_EN
   logic                ld_valid;
   logic [ADDR_W-1:0]   ld_addr;
   logic                fwd_hit;
   logic [DATA_W-1:0]   fwd_data;

   modport slave (
      input  enq_valid, enq_kill, enq_addr, enq_data, reqack, writeack, ld_valid, ld_addr,
      output enq_ready, reqcyc, req, reqdata, reqtag, store_done, count, empty, fwd_hit, fwd_data
   );
   modport master (
      output enq_valid, enq_kill, enq_addr, enq_data, reqack, writeack, ld_valid, ld_addr,
      input  enq_ready, reqcyc, req, reqdata, reqtag, store_done, count, empty, fwd_hit, fwd_data
   );
`else
   modport slave (
      input  enq_valid, enq_kill, enq_addr, enq_data, reqack, writeack,
      output enq_ready, reqcyc, req, reqdata, reqtag, store_done, count, empty
   );
   modport master (
      output enq_valid, enq_kill, enq_addr, enq_data, reqack, writeack,
      input  enq_ready, reqcyc, req, reqdata, reqtag, store_done, count, empty
   );
`endif

endinterface

// File: rtl/wb_stq_fwd_cam.sv
// Store-to-load forwarding CAM: exact address match over occupied entries,
// youngest matching entry supplies the data. Used only with WB_STQ_FWD_EN.
module wb_stq_fwd_cam
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64
) (
   input  stq_entry_t                 entries_i [DEPTH],
   input  logic [$clog2(DEPTH)-1:0]   head_i,
   input  logic [$clog2(DEPTH):0]     count_i,
   input  logic                       ld_valid_i,
   input  logic [ADDR_W-1:0]          ld_addr_i,
   output logic                       hit_o,
   output logic [DATA_W-1:0]          data_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] idx;

   // Walk from oldest (head) to youngest; later matches overwrite earlier ones
   always_comb begin
      hit_o  = 1'b0;
      data_o = '0;
      idx    = head_i;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         idx = head_i + PTR_W'(k);
         if (ld_valid_i && (CNT_W'(k) < count_i) &&
             (entries_i[idx].addr[ADDR_W-1:0] == ld_addr_i)) begin
            hit_o  = 1'b1;
            data_o = entries_i[idx].data[DATA_W-1:0];
         end
      end
   end

endmodule

// File: rtl/wb_store_queue.sv
// Write-back store queue: buffers up to DEPTH committed stores and drains
// them in order to the D-cache via reqcyc/reqack/writeack.
// Optional store-to-load forwarding is enabled with WB_STQ_FWD_EN.
// ADDR_W and DATA_W must not exceed 64.
module wb_store_queue
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64
) (
   input  logic            clk,
   input  logic            reset,
   wb_store_queue_if.slave stq
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   stq_entry_t        mem_q [DEPTH];
   stq_entry_t        wr_entry;
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   stq_state_e        state_q, state_d;
   logic [ADDR_W-1:0] req_q, req_d;
   logic [DATA_W-1:0] reqdata_q, reqdata_d;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic              load;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign push  = stq.enq_valid && !full && !stq.enq_kill;
   assign pop   = (state_q == RETIRE);
   assign load  = (state_q == IDLE) && !empty;

   assign wr_entry.addr = STQ_ADDR_MAX_W'(stq.enq_addr);
   assign wr_entry.data = STQ_DATA_MAX_W'(stq.enq_data);

   // Drain FSM next-state: one head entry outstanding at a time
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!empty) state_d = REQ;
         REQ:     if (stq.reqack) state_d = stq.writeack ? RETIRE : WAIT;
         WAIT:    if (stq.writeack) state_d = RETIRE;
         RETIRE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Drain FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Pointer, occupancy and bus-request next-state
   always_comb begin
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      req_d     = req_q;
      reqdata_d = reqdata_q;
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
      if (load) begin
         req_d     = mem_q[head_q].addr[ADDR_W-1:0];
         reqdata_d = mem_q[head_q].data[DATA_W-1:0];
      end
   end

   // Pointer, occupancy and bus-request registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         req_q     <= '0;
         reqdata_q <= '0;
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         req_q     <= req_d;
         reqdata_q <= reqdata_d;
      end
   end

   // Entry storage; only occupied slots are ever read, so no reset needed
   always_ff @(posedge clk) begin
      if (push) mem_q[tail_q] <= wr_entry;
   end

   assign stq.enq_ready  = !full;
   assign stq.reqcyc     = (state_q == REQ);
   assign stq.req        = req_q;
   assign stq.reqdata    = reqdata_q;
   assign stq.reqtag     = STORE_TAG;
   assign stq.store_done = (state_q == RETIRE);
   assign stq.count      = count_q;
   assign stq.empty      = empty;

`ifdef WB_STQ_FWD_EN
   wb_stq_fwd_cam #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_fwd_cam (
      .entries_i  (mem_q),
      .head_i     (head_q),
      .count_i    (count_q),
      .ld_valid_i (stq.ld_valid),
      .ld_addr_i  (stq.ld_addr),
      .hit_o      (stq.fwd_hit),
      .data_o     (stq.fwd_data)
   );
`endif

endmodule

// File: tb/tb_wb_store_queue.sv
// Directed self-checking bench for wb_store_queue (DEPTH=4, 64-bit address/data).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_wb_store_queue;

   logic clk = 1'b0;
   logic reset;
   int   ncmp = 0;
   int   nerr = 0;

   localparam logic [9:0] EXP_TAG = 10'h380;

   always #5 clk = ~clk;

   wb_store_queue_if #(.DEPTH(4), .ADDR_W(64), .DATA_W(64)) stq_bus ();

   wb_store_queue #(.DEPTH(4), .ADDR_W(64), .DATA_W(64)) dut (
      .clk   (clk),
      .reset (reset),
      .stq   (stq_bus)
   );

   task automatic idle_inputs();
      stq_bus.enq_valid = 1'b0;
      stq_bus.enq_kill  = 1'b0;
      stq_bus.enq_addr  = '0;
      stq_bus.enq_data  = '0;
      stq_bus.reqack    = 1'b0;
      stq_bus.writeack  = 1'b0;
`ifdef WB_STQ_FWD_EN
      stq_bus.ld_valid  = 1'b0;
      stq_bus.ld_addr   = '0;
`endif
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      repeat (3) @(negedge clk);
      ncmp++; if (stq_bus.reqcyc !== 1'b0) begin nerr++; $display("FAIL reset_reqcyc: got %b want 0", stq_bus.reqcyc); end
      ncmp++; if (stq_bus.store_done !== 1'b0) begin nerr++; $display("FAIL reset_store_done: got %b want 0", stq_bus.store_done); end
      ncmp++; if (stq_bus.count !== 3'd0) begin nerr++; $display("FAIL reset_count: got %0d want 0", stq_bus.count); end
      ncmp++; if (stq_bus.empty !== 1'b1) begin nerr++; $display("FAIL reset_empty: got %b want 1", stq_bus.empty); end
      ncmp++; if (stq_bus.req !== 64'h0) begin nerr++; $display("FAIL reset_req: got %h want 0", stq_bus.req); end
      reset = 1'b0;
      @(negedge clk);
      ncmp++; if (stq_bus.reqcyc !== 1'b0 || stq_bus.count !== 3'd0) begin nerr++; $display("FAIL post_reset_idle: reqcyc %b count %0d want 0 0", stq_bus.reqcyc, stq_bus.count); end
   endtask

   task automatic test_single_store();
      @(negedge clk); // c0
      stq_bus.enq_valid = 1'b1; stq_bus.enq_addr = 64'h1000; stq_bus.enq_data = 64'hDEAD;
      @(negedge clk); // c1
      stq_bus.enq_valid = 1'b0;
      ncmp++; if (stq_bus.count !== 3'd1) begin nerr++; $display("FAIL single_count: got %0d want 1", stq_bus.count); end
      ncmp++; if (stq_bus.reqcyc !== 1'b0) begin nerr++; $display("FAIL single_reqcyc_early: got %b want 0", stq_bus.reqcyc); end
      @(negedge clk); // c2
      ncmp++; if (stq_bus.reqcyc !== 1'b1) begin nerr++; $display("FAIL single_reqcyc_rise: got %b want 1", stq_bus.reqcyc); end
      ncmp++; if (stq_bus.req !== 64'h1000) begin nerr++; $display("FAIL single_req: got %h want 1000", stq_bus.req); end
      ncmp++; if (stq_bus.reqdata !== 64'hDEAD) begin nerr++; $display("FAIL single_reqdata: got %h want dead", stq_bus.reqdata); end
      ncmp++; if (stq_bus.reqtag !== EXP_TAG) begin nerr++; $display("FAIL single_reqtag: got %h want %h", stq_bus.reqtag, EXP_TAG); end
      @(negedge clk); // c3
      stq_bus.reqack = 1'b1;
      @(negedge clk); // c4
      stq_bus.reqack = 1'b0;
      ncmp++; if (stq_bus.reqcyc !== 1'b0) begin nerr++; $display("FAIL single_reqcyc_drop: got %b want 0", stq_bus.reqcyc); end
      @(negedge clk); // c5
      ncmp++; if (stq_bus.store_done !== 1'b0) begin nerr++; $display("FAIL single_done_early: got %b want 0", stq_bus.store_done); end
      stq_bus.writeack = 1'b1;
      @(negedge clk); // c6
      stq_bus.writeack = 1'b0;
      ncmp++; if (stq_bus.store_done !== 1'b1) begin nerr++; $display("FAIL single_done: got %b want 1", stq_bus.store_done); end
      @(negedge clk); // c7
      ncmp++; if (stq_bus.store_done !== 1'b0) begin nerr++; $display("FAIL single_done_pulse: got %b want 0", stq_bus.store_done); end
      ncmp++; if (stq_bus.empty !== 1'b1 || stq_bus.count !== 3'd0) begin nerr++; $display("FAIL single_empty: empty %b count %0d want 1 0", stq_bus.empty, stq_bus.count); end
   endtask

   task automatic test_fill();
      int n;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         stq_bus.enq_valid = 1'b1;
         stq_bus.enq_addr  = 64'h100 + 64'(8 * i);
         stq_bus.enq_data  = 64'hA0 + 64'(i);
      end
      @(negedge clk); // c4
      ncmp++; if (stq_bus.count !== 3'd4) begin nerr++; $display("FAIL fill_count: got %0d want 4", stq_bus.count); end
      ncmp++; if (stq_bus.enq_ready !== 1'b0) begin nerr++; $display("FAIL fill_ready_full: got %b want 0", stq_bus.enq_ready); end
      stq_bus.enq_addr = 64'h200; stq_bus.enq_data = 64'hFF;
      @(negedge clk); // c5
      stq_bus.enq_valid = 1'b0;
      ncmp++; if (stq_bus.count !== 3'd4) begin nerr++; $display("FAIL fill_5th_rejected: count %0d want 4", stq_bus.count); end
      ncmp++; if (stq_bus.reqcyc !== 1'b1 || stq_bus.req !== 64'h100) begin nerr++; $display("FAIL fill_head_req: reqcyc %b req %h want 1 100", stq_bus.reqcyc, stq_bus.req); end
      stq_bus.reqack = 1'b1; stq_bus.writeack = 1'b1;
      @(negedge clk); // c6
      stq_bus.reqack = 1'b0; stq_bus.writeack = 1'b0;
      ncmp++; if (stq_bus.store_done !== 1'b1) begin nerr++; $display("FAIL fill_first_done: got %b want 1", stq_bus.store_done); end
      @(negedge clk); // c7
      ncmp++; if (stq_bus.count !== 3'd3 || stq_bus.enq_ready !== 1'b1) begin nerr++; $display("FAIL fill_ready_after_retire: count %0d ready %b want 3 1", stq_bus.count, stq_bus.enq_ready); end
      for (int i = 1; i < 4; i++) begin
         n = 0;
         while (stq_bus.reqcyc !== 1'b1 && n < 10) begin @(negedge clk); n++; end
         ncmp++;
         if (stq_bus.req !== 64'h100 + 64'(8 * i) || stq_bus.reqdata !== 64'hA0 + 64'(i) || stq_bus.reqcyc !== 1'b1) begin
            nerr++; $display("FAIL fill_order_%0d: reqcyc %b req %h data %h want 1 %h %h", i, stq_bus.reqcyc, stq_bus.req, stq_bus.reqdata, 64'h100 + 64'(8 * i), 64'hA0 + 64'(i));
         end
         stq_bus.reqack = 1'b1; stq_bus.writeack = 1'b1;
         @(negedge clk);
         stq_bus.reqack = 1'b0; stq_bus.writeack = 1'b0;
         ncmp++; if (stq_bus.store_done !== 1'b1) begin nerr++; $display("FAIL fill_done_%0d: got %b want 1", i, stq_bus.store_done); end
      end
      @(negedge clk);
      ncmp++; if (stq_bus.empty !== 1'b1) begin nerr++; $display("FAIL fill_drained: empty %b want 1", stq_bus.empty); end
   endtask

   task automatic test_stall();
      int done_cnt;
      @(negedge clk); // c0
      stq_bus.enq_valid = 1'b1; stq_bus.enq_addr = 64'h3000; stq_bus.enq_data = 64'h3333;
      @(negedge clk); // c1
      stq_bus.enq_valid = 1'b0;
      @(negedge clk); // c2
      for (int i = 0; i < 10; i++) begin
         ncmp++;
         if (stq_bus.reqcyc !== 1'b1 || stq_bus.req !== 64'h3000 || stq_bus.reqdata !== 64'h3333 || stq_bus.store_done !== 1'b0) begin
            nerr++; $display("FAIL stall_hold_%0d: reqcyc %b req %h data %h done %b want 1 3000 3333 0", i, stq_bus.reqcyc, stq_bus.req, stq_bus.reqdata, stq_bus.store_done);
         end
         stq_bus.writeack = (i == 2); // stray writeack without reqack must be ignored
         @(negedge clk);
      end
      ncmp++; if (stq_bus.reqcyc !== 1'b1) begin nerr++; $display("FAIL stall_still_req: got %b want 1", stq_bus.reqcyc); end
      stq_bus.reqack = 1'b1; stq_bus.writeack = 1'b1;
      @(negedge clk);
      stq_bus.reqack = 1'b0; stq_bus.writeack = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         if (stq_bus.store_done === 1'b1) done_cnt++;
         @(negedge clk);
      end
      ncmp++; if (done_cnt != 1) begin nerr++; $display("FAIL stall_done_once: got %0d pulses want 1", done_cnt); end
      ncmp++; if (stq_bus.empty !== 1'b1) begin nerr++; $display("FAIL stall_empty: got %b want 1", stq_bus.empty); end
   endtask

   task automatic test_kill();
      logic any_bus;
      @(negedge clk);
      stq_bus.enq_valid = 1'b1; stq_bus.enq_kill = 1'b1; stq_bus.enq_addr = 64'h4000; stq_bus.enq_data = 64'h44;
      @(negedge clk);
      @(negedge clk);
      stq_bus.enq_valid = 1'b0; stq_bus.enq_kill = 1'b0;
      ncmp++; if (stq_bus.count !== 3'd0) begin nerr++; $display("FAIL kill_count: got %0d want 0", stq_bus.count); end
      any_bus = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (stq_bus.reqcyc !== 1'b0 || stq_bus.store_done !== 1'b0) any_bus = 1'b1;
         @(negedge clk);
      end
      ncmp++; if (any_bus !== 1'b0) begin nerr++; $display("FAIL kill_no_bus: activity %b want 0", any_bus); end
      ncmp++; if (stq_bus.empty !== 1'b1) begin nerr++; $display("FAIL kill_empty: got %b want 1", stq_bus.empty); end
   endtask

   task automatic test_reset_mid();
      logic any_done;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         stq_bus.enq_valid = 1'b1;
         stq_bus.enq_addr  = 64'h5000 + 64'(i);
         stq_bus.enq_data  = 64'h50 + 64'(i);
      end
      @(negedge clk); // c3
      stq_bus.enq_valid = 1'b0;
      ncmp++; if (stq_bus.reqcyc !== 1'b1 || stq_bus.count !== 3'd3) begin nerr++; $display("FAIL rstmid_pre: reqcyc %b count %0d want 1 3", stq_bus.reqcyc, stq_bus.count); end
      #2 reset = 1'b1;
      #1;
      ncmp++; if (stq_bus.reqcyc !== 1'b0) begin nerr++; $display("FAIL rstmid_reqcyc_async: got %b want 0", stq_bus.reqcyc); end
      ncmp++; if (stq_bus.count !== 3'd0 || stq_bus.empty !== 1'b1) begin nerr++; $display("FAIL rstmid_count: count %0d empty %b want 0 1", stq_bus.count, stq_bus.empty); end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      stq_bus.writeack = 1'b1;
      @(negedge clk);
      stq_bus.writeack = 1'b0;
      any_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (stq_bus.store_done !== 1'b0 || stq_bus.reqcyc !== 1'b0) any_done = 1'b1;
         @(negedge clk);
      end
      ncmp++; if (any_done !== 1'b0) begin nerr++; $display("FAIL rstmid_stray_writeack: activity %b want 0", any_done); end
   endtask

`ifdef WB_STQ_FWD_EN
   task automatic test_fwd();
      int n;
      @(negedge clk);
      stq_bus.enq_valid = 1'b1; stq_bus.enq_addr = 64'h20; stq_bus.enq_data = 64'h11;
      @(negedge clk);
      stq_bus.enq_data = 64'h22;
      @(negedge clk);
      stq_bus.enq_valid = 1'b0;
      stq_bus.ld_valid = 1'b0; stq_bus.ld_addr = 64'h20;
      #1;
      ncmp++; if (stq_bus.fwd_hit !== 1'b0) begin nerr++; $display("FAIL fwd_no_ld_valid: got %b want 0", stq_bus.fwd_hit); end
      stq_bus.ld_valid = 1'b1;
      #1;
      ncmp++; if (stq_bus.fwd_hit !== 1'b1 || stq_bus.fwd_data !== 64'h22) begin nerr++; $display("FAIL fwd_youngest: hit %b data %h want 1 22", stq_bus.fwd_hit, stq_bus.fwd_data); end
      stq_bus.ld_addr = 64'h24;
      #1;
      ncmp++; if (stq_bus.fwd_hit !== 1'b0) begin nerr++; $display("FAIL fwd_miss: got %b want 0", stq_bus.fwd_hit); end
      stq_bus.ld_addr = 64'h20;
      for (int i = 0; i < 2; i++) begin
         n = 0;
         while (stq_bus.reqcyc !== 1'b1 && n < 10) begin @(negedge clk); n++; end
         ncmp++; if (stq_bus.reqcyc !== 1'b1) begin nerr++; $display("FAIL fwd_drain_%0d: reqcyc %b want 1", i, stq_bus.reqcyc); end
         stq_bus.reqack = 1'b1; stq_bus.writeack = 1'b1;
         @(negedge clk);
         stq_bus.reqack = 1'b0; stq_bus.writeack = 1'b0;
      end
      @(negedge clk);
      ncmp++; if (stq_bus.fwd_hit !== 1'b0 || stq_bus.empty !== 1'b1) begin nerr++; $display("FAIL fwd_after_retire: hit %b empty %b want 0 1", stq_bus.fwd_hit, stq_bus.empty); end
      stq_bus.ld_valid = 1'b0;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_store();
      test_fill();
      test_stall();
      test_kill();
      test_reset_mid();
`ifdef WB_STQ_FWD_EN
      test_fwd();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
